// File: rtl/usb2_ep0_pkg.sv
// Shared definitions for the EP0 IN data-stage sequencer.
//   ep0_state_t        sequencer state encoding
//   EP0_BUF_DEPTH      bytes in the EP0 IN buffer RAM
//   EP0_ADR_W/LEN_W    buffer address width / transfer length width (0..64)
//   EP0_MAX_PKT_*      legal EP0 max packet sizes
//   EP0_SKID_DEPTH     output skid entries (RAM latency plus one)
//   ep0_max_pkt_legal  true for a legal EP0 max packet size
//   ep0_pkt_len        bytes in the next packet given length, base and max packet
//   ep0_clamp_len      limits an armed length to the buffer size
package usb2_ep0_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READY   = 3'd1,
    ST_FETCH   = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_HS = 3'd4,
    ST_DONE    = 3'd5
  } ep0_state_t;

  localparam int EP0_BUF_DEPTH  = 64;
  localparam int EP0_ADR_W      = 6;
  localparam int EP0_LEN_W      = 7;
  localparam int EP0_SKID_DEPTH = 3;

  localparam int EP0_MAX_PKT_8  = 8;
  localparam int EP0_MAX_PKT_16 = 16;
  localparam int EP0_MAX_PKT_32 = 32;
  localparam int EP0_MAX_PKT_64 = 64;

  function automatic bit ep0_max_pkt_legal(input int mp);
    return (mp == EP0_MAX_PKT_8)  || (mp == EP0_MAX_PKT_16) ||
           (mp == EP0_MAX_PKT_32) || (mp == EP0_MAX_PKT_64);
  endfunction

  // len >= base always holds while a transfer is live, so the subtraction
  // never wraps.
  function automatic logic [EP0_LEN_W-1:0] ep0_pkt_len(
    input logic [EP0_LEN_W-1:0] len,
    input logic [EP0_LEN_W-1:0] base,
    input logic [EP0_LEN_W-1:0] max_pkt
  );
    logic [EP0_LEN_W-1:0] rem;
    rem = len - base;
    return (rem > max_pkt) ? max_pkt : rem;
  endfunction

  function automatic logic [EP0_LEN_W-1:0] ep0_clamp_len(input logic [EP0_LEN_W-1:0] l);
    return (l > 7'(EP0_BUF_DEPTH)) ? 7'(EP0_BUF_DEPTH) : l;
  endfunction

endpackage

// File: rtl/usb2_ep0in_ram.sv
// EP0 IN buffer RAM: 64x8, one write port, one read port, two-clock read
// latency (address registered into the array read, then one output stage).
//   clk     clock
//   we      write strobe
//   wr_adr  write address
//   wr_dat  write data
//   rd_adr  read address, sampled every clock
//   rd_dat  read data, valid two clocks after rd_adr was presented
module usb2_ep0in_ram
  import usb2_ep0_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic [EP0_ADR_W-1:0] wr_adr,
  input  logic [7:0]           wr_dat,
  input  logic [EP0_ADR_W-1:0] rd_adr,
  output logic [7:0]           rd_dat
);

  logic [7:0] mem [EP0_BUF_DEPTH];
  logic [7:0] rd_stage;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_adr] <= wr_dat;
    end
    rd_stage <= mem[rd_adr];
    rd_dat   <= rd_stage;
  end

endmodule

// File: rtl/usb2_ep0in_ctrl.sv
// EP0 IN data-stage sequencer. Owns the EP0 IN buffer RAM, splits an armed
// transfer into MAX_PKT packets, streams bytes to the packet engine with
// backpressure, resends on handshake timeout, NAKs when unarmed and appends a
// ZLP on request.
//   clk, reset_n          clock, synchronous active-low reset
//   buf_we/adr/dat        loader write port (accepted only in IDLE)
//   arm, arm_len, arm_zlp start a transfer of arm_len bytes (clamped to 64)
//   abort                 drop the transfer, back to IDLE next clock
//   pkt_req/ack/retry     IN token, host ACK, handshake timeout
//   tx_valid/dat/last     byte stream to the packet engine, tx_ready accepts
//   tx_zlp                send a zero-length DATA packet
//   nak                   IN token while unarmed
//   busy, done            transfer in progress / final packet ACKed
//   buf_err               loader write dropped because not IDLE
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no transfer; loader may write the RAM; IN tokens are NAKed
// READY    | armed, waiting for an IN token for the packet at base
// FETCH    | reads issued for the packet, first byte not yet in the skid
// SEND     | bytes streaming out of the skid buffer
// WAIT_HS  | whole packet handed over, waiting for ACK or timeout
// DONE     | final packet ACKed; done pulses, then IDLE
module usb2_ep0in_ctrl
  import usb2_ep0_pkg::*;
#(
  parameter int MAX_PKT = 64
)
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 buf_we,
  input  logic [EP0_ADR_W-1:0] buf_adr,
  input  logic [7:0]           buf_dat,
  input  logic                 arm,
  input  logic [EP0_LEN_W-1:0] arm_len,
  input  logic                 arm_zlp,
  input  logic                 abort,
  input  logic                 pkt_req,
  input  logic                 pkt_ack,
  input  logic                 pkt_retry,
  output logic                 tx_valid,
  output logic [7:0]           tx_dat,
  output logic                 tx_last,
  output logic                 tx_zlp,
  input  logic                 tx_ready,
  output logic                 nak,
  output logic                 busy,
  output logic                 done,
  output logic                 buf_err
);

  // An illegal MAX_PKT falls back to the full-speed/high-speed maximum.
  localparam logic [EP0_LEN_W-1:0] MAX_PKT_L =
    ep0_max_pkt_legal(MAX_PKT) ? 7'(MAX_PKT) : 7'(EP0_MAX_PKT_64);

  ep0_state_t           state;
  logic [EP0_LEN_W-1:0] len_q;
  logic [EP0_LEN_W-1:0] base_q;
  logic [EP0_LEN_W-1:0] pkt_len_q;
  logic [EP0_LEN_W-1:0] iss_left;
  logic                 zlp_q;
  logic [EP0_ADR_W-1:0] rd_ptr;

  logic [EP0_LEN_W-1:0] pkt_len;
  logic [EP0_LEN_W-1:0] base_sum;

  // Read pipeline tags: stage 1 and stage 2 track the two RAM read stages.
  logic v1, l1, v2, l2;

  logic [7:0] skid_dat    [EP0_SKID_DEPTH];
  logic       skid_last   [EP0_SKID_DEPTH];
  logic [1:0] skid_cnt;
  logic [7:0] skid_dat_n  [EP0_SKID_DEPTH];
  logic       skid_last_n [EP0_SKID_DEPTH];
  logic [1:0] skid_cnt_n;

  logic       ram_we;
  logic [7:0] ram_rd_dat;
  logic       streaming;
  logic       pop;
  logic       push;
  logic       issue;
  logic       issue_last;
  logic [2:0] occ;

  usb2_ep0in_ram u_ram (
    .clk    (clk),
    .we     (ram_we),
    .wr_adr (buf_adr),
    .wr_dat (buf_dat),
    .rd_adr (rd_ptr),
    .rd_dat (ram_rd_dat)
  );

  assign ram_we   = buf_we && (state == ST_IDLE);
  assign pkt_len  = ep0_pkt_len(len_q, base_q, MAX_PKT_L);
  assign base_sum = base_q + pkt_len_q;

  assign tx_valid = (skid_cnt != 2'd0);
  assign tx_dat   = skid_dat[0];
  assign tx_last  = tx_valid && skid_last[0];

  assign streaming = (state == ST_FETCH) || (state == ST_SEND);
  assign pop       = tx_valid && tx_ready;
  assign push      = v2;

  // Worst-case skid occupancy if nothing else pops: what stays after this
  // clock plus every read still in flight. A new read is issued only if it
  // still fits, which keeps 1 byte/clk when the head is popped every clock.
  always_comb begin
    occ        = {1'b0, skid_cnt} - {2'b0, pop} + {2'b0, v1} + {2'b0, v2};
    issue      = streaming && (iss_left != '0) && (occ < 3'd3);
    issue_last = issue && (iss_left == 7'd1);
  end

  always_comb begin
    skid_dat_n  = skid_dat;
    skid_last_n = skid_last;
    skid_cnt_n  = skid_cnt;
    if (pop) begin
      for (int i = 0; i < EP0_SKID_DEPTH - 1; i++) begin
        skid_dat_n[i]  = skid_dat[i+1];
        skid_last_n[i] = skid_last[i+1];
      end
      skid_cnt_n = skid_cnt - 2'd1;
    end
    if (push) begin
      for (int i = 0; i < EP0_SKID_DEPTH; i++) begin
        if (2'(i) == skid_cnt_n) begin
          skid_dat_n[i]  = ram_rd_dat;
          skid_last_n[i] = l2;
        end
      end
      skid_cnt_n = skid_cnt_n + 2'd1;
    end
  end

  // Skid buffer and read-pipeline tags. Abort drops the tags so reads already
  // in the RAM pipeline never reach the skid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      skid_cnt <= 2'd0;
      v1 <= 1'b0;
      l1 <= 1'b0;
      v2 <= 1'b0;
      l2 <= 1'b0;
      for (int i = 0; i < EP0_SKID_DEPTH; i++) begin
        skid_dat[i]  <= 8'h00;
        skid_last[i] <= 1'b0;
      end
    end else if (abort) begin
      skid_cnt <= 2'd0;
      v1 <= 1'b0;
      l1 <= 1'b0;
      v2 <= 1'b0;
      l2 <= 1'b0;
    end else begin
      skid_cnt  <= skid_cnt_n;
      skid_dat  <= skid_dat_n;
      skid_last <= skid_last_n;
      v1 <= issue;
      l1 <= issue_last;
      v2 <= v1;
      l2 <= l1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      base_q    <= '0;
      pkt_len_q <= '0;
      iss_left  <= '0;
      zlp_q     <= 1'b0;
      rd_ptr    <= '0;
      tx_zlp    <= 1'b0;
      nak       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      buf_err   <= 1'b0;
    end else begin
      tx_zlp  <= 1'b0;
      nak     <= 1'b0;
      done    <= 1'b0;
      buf_err <= buf_we && (state != ST_IDLE);

      if (issue) begin
        rd_ptr   <= rd_ptr + 6'd1;
        iss_left <= iss_left - 7'd1;
      end

      if (abort) begin
        state    <= ST_IDLE;
        base_q   <= '0;
        iss_left <= '0;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (pkt_req) begin
              nak <= 1'b1;
            end
            if (arm) begin
              len_q  <= ep0_clamp_len(arm_len);
              zlp_q  <= arm_zlp;
              base_q <= '0;
              busy   <= 1'b1;
              state  <= ST_READY;
            end
          end

          ST_READY: begin
            if (pkt_req) begin
              pkt_len_q <= pkt_len;
              if (pkt_len == '0) begin
                tx_zlp <= 1'b1;
                state  <= ST_WAIT_HS;
              end else begin
                rd_ptr   <= base_q[EP0_ADR_W-1:0];
                iss_left <= pkt_len;
                state    <= ST_FETCH;
              end
            end
          end

          ST_FETCH: begin
            if (v2) begin
              state <= ST_SEND;
            end
          end

          ST_SEND: begin
            if (pop && skid_last[0]) begin
              state <= ST_WAIT_HS;
            end
          end

          ST_WAIT_HS: begin
            if (pkt_ack) begin
              base_q <= base_sum;
              // A full packet that ends the data may still owe a ZLP.
              if ((pkt_len_q < MAX_PKT_L) || ((base_sum == len_q) && !zlp_q)) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_DONE;
              end else begin
                state <= ST_READY;
              end
            end else if (pkt_retry) begin
              state <= ST_READY;
            end
          end

          ST_DONE: begin
            state <= ST_IDLE;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb2_ep0in_ctrl.sv
// Bench for usb2_ep0in_ctrl: one instance with MAX_PKT=64 and one with
// MAX_PKT=8 share the stimulus; sel routes the control strobes to one of them
// and picks which outputs are observed.
module tb_usb2_ep0in_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, sel;
  logic       buf_we, arm, arm_zlp, abort, pkt_req, pkt_ack, pkt_retry, tx_ready;
  logic [5:0] buf_adr;
  logic [7:0] buf_dat;
  logic [6:0] arm_len;

  logic a_we, a_arm, a_abort, a_req, a_ack, a_retry;
  logic b_we, b_arm, b_abort, b_req, b_ack, b_retry;
  assign a_we    = buf_we    & ~sel;
  assign a_arm   = arm       & ~sel;
  assign a_abort = abort     & ~sel;
  assign a_req   = pkt_req   & ~sel;
  assign a_ack   = pkt_ack   & ~sel;
  assign a_retry = pkt_retry & ~sel;
  assign b_we    = buf_we    & sel;
  assign b_arm   = arm       & sel;
  assign b_abort = abort     & sel;
  assign b_req   = pkt_req   & sel;
  assign b_ack   = pkt_ack   & sel;
  assign b_retry = pkt_retry & sel;

  logic       a_tx_valid, a_tx_last, a_tx_zlp, a_nak, a_busy, a_done, a_buf_err;
  logic       b_tx_valid, b_tx_last, b_tx_zlp, b_nak, b_busy, b_done, b_buf_err;
  logic [7:0] a_tx_dat, b_tx_dat;

  logic       tx_valid, tx_last, tx_zlp, nak, busy, done, buf_err;
  logic [7:0] tx_dat;
  assign tx_valid = sel ? b_tx_valid : a_tx_valid;
  assign tx_last  = sel ? b_tx_last  : a_tx_last;
  assign tx_zlp   = sel ? b_tx_zlp   : a_tx_zlp;
  assign nak      = sel ? b_nak      : a_nak;
  assign busy     = sel ? b_busy     : a_busy;
  assign done     = sel ? b_done     : a_done;
  assign buf_err  = sel ? b_buf_err  : a_buf_err;
  assign tx_dat   = sel ? b_tx_dat   : a_tx_dat;

  usb2_ep0in_ctrl #(.MAX_PKT(64)) u_d64 (
    .clk(clk), .reset_n(reset_n), .buf_we(a_we), .buf_adr(buf_adr), .buf_dat(buf_dat),
    .arm(a_arm), .arm_len(arm_len), .arm_zlp(arm_zlp), .abort(a_abort),
    .pkt_req(a_req), .pkt_ack(a_ack), .pkt_retry(a_retry),
    .tx_valid(a_tx_valid), .tx_dat(a_tx_dat), .tx_last(a_tx_last), .tx_zlp(a_tx_zlp),
    .tx_ready(tx_ready), .nak(a_nak), .busy(a_busy), .done(a_done), .buf_err(a_buf_err)
  );

  usb2_ep0in_ctrl #(.MAX_PKT(8)) u_d8 (
    .clk(clk), .reset_n(reset_n), .buf_we(b_we), .buf_adr(buf_adr), .buf_dat(buf_dat),
    .arm(b_arm), .arm_len(arm_len), .arm_zlp(arm_zlp), .abort(b_abort),
    .pkt_req(b_req), .pkt_ack(b_ack), .pkt_retry(b_retry),
    .tx_valid(b_tx_valid), .tx_dat(b_tx_dat), .tx_last(b_tx_last), .tx_zlp(b_tx_zlp),
    .tx_ready(tx_ready), .nak(b_nak), .busy(b_busy), .done(b_done), .buf_err(b_buf_err)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] mem_m [2][64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 64; i++) begin
      buf_we  = 1'b1;
      buf_adr = 6'(i);
      buf_dat = 8'($urandom);
      mem_m[sel][i] = buf_dat;
      tick();
    end
    buf_we = 1'b0;
    checks++;
    if (buf_err !== 1'b0) begin
      failures++;
      $display("FAIL load_buf_err: buf_err=%b want 0", buf_err);
    end
  endtask

  task automatic do_arm(input int len_raw, input bit zlp, input string tag);
    arm_len = 7'(len_raw);
    arm_zlp = zlp;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_after_arm: busy=%b want 1", tag, busy);
    end
  endtask

  // Request one data packet and collect it, comparing against the model RAM.
  task automatic recv_packet(input int pbase, input int plen, input bit rnd, input string tag);
    int got, lat, budget;
    bit prev_stall;
    logic [7:0] prev_dat;
    tx_ready = 1'b1;
    pkt_req = 1'b1;
    tick();
    pkt_req = 1'b0;
    lat = 0;
    while (tx_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL %s first_valid_latency: got %0d clk want 3", tag, lat);
    end
    got = 0;
    budget = 0;
    prev_stall = 1'b0;
    prev_dat = 8'h00;
    while (got < plen && budget < 600) begin
      tx_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (prev_stall) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_dat !== prev_dat) begin
          failures++;
          $display("FAIL %s stall_hold: valid=%b dat=%h want 1 %h", tag, tx_valid, tx_dat, prev_dat);
        end
      end
      if (!rnd && got > 0) begin
        checks++;
        if (tx_valid !== 1'b1) begin
          failures++;
          $display("FAIL %s throughput_gap at byte %0d", tag, got);
        end
      end
      if (tx_valid === 1'b1) begin
        if (tx_ready) begin
          checks++;
          if (tx_dat !== mem_m[sel][pbase + got]) begin
            failures++;
            $display("FAIL %s byte[%0d]: got %h want %h", tag, pbase + got, tx_dat, mem_m[sel][pbase + got]);
          end
          checks++;
          if (tx_last !== (got == plen - 1)) begin
            failures++;
            $display("FAIL %s tx_last at byte %0d: got %b want %b", tag, got, tx_last, got == plen - 1);
          end
          got++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_dat = tx_dat;
        end
      end else begin
        prev_stall = 1'b0;
      end
      tick();
      budget++;
    end
    tx_ready = 1'b1;
    checks++;
    if (got != plen) begin
      failures++;
      $display("FAIL %s byte_count_timeout: got %0d want %0d", tag, got, plen);
    end
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s extra_byte: tx_valid=%b want 0", tag, tx_valid);
    end
  endtask

  task automatic recv_zlp(input string tag);
    pkt_req = 1'b1;
    tick();
    pkt_req = 1'b0;
    checks++;
    if (tx_zlp !== 1'b1 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s zlp: tx_zlp=%b tx_valid=%b want 1 0", tag, tx_zlp, tx_valid);
    end
    tick();
    checks++;
    if (tx_zlp !== 1'b0) begin
      failures++;
      $display("FAIL %s zlp_pulse_width: tx_zlp=%b want 0", tag, tx_zlp);
    end
  endtask

  // Reference: packet sizes follow from length, MAX_PKT and the ZLP flag.
  task automatic run_transfer(input int len_raw, input bit zlp, input bit rnd,
                              input int retry_idx, input bit dual, input string tag);
    int maxp, len, rem, p, base;
    int plist[$];
    bit last;
    maxp = sel ? 8 : 64;
    len = (len_raw > 64) ? 64 : len_raw;
    rem = len;
    while (1) begin
      p = (rem < maxp) ? rem : maxp;
      plist.push_back(p);
      rem -= p;
      if (p < maxp) break;
      if (rem == 0) begin
        if (zlp) plist.push_back(0);
        break;
      end
    end
    do_arm(len_raw, zlp, tag);
    base = 0;
    for (int i = 0; i < plist.size(); i++) begin
      if (plist[i] > 0) recv_packet(base, plist[i], rnd, tag);
      else recv_zlp(tag);
      if (i == retry_idx) begin
        pkt_retry = 1'b1;
        tick();
        pkt_retry = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL %s retry_state: done=%b busy=%b want 0 1", tag, done, busy);
        end
        if (plist[i] > 0) recv_packet(base, plist[i], rnd, tag);
        else recv_zlp(tag);
      end
      last = (i == plist.size() - 1);
      pkt_ack = 1'b1;
      pkt_retry = dual;
      tick();
      pkt_ack = 1'b0;
      pkt_retry = 1'b0;
      checks++;
      if (done !== last || busy !== !last) begin
        failures++;
        $display("FAIL %s ack_pkt%0d: done=%b busy=%b want %b %b", tag, i, done, busy, last, !last);
      end
      base += plist[i];
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done: done=%b busy=%b want 0 0", tag, done, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({a_tx_valid, a_tx_last, a_tx_zlp, a_nak, a_busy, a_done, a_buf_err} !== 7'b0 || a_tx_dat !== 8'h00) begin
      failures++;
      $display("FAIL reset_d64: flags=%b dat=%h want 0", {a_tx_valid, a_tx_last, a_tx_zlp, a_nak, a_busy, a_done, a_buf_err}, a_tx_dat);
    end
    checks++;
    if ({b_tx_valid, b_tx_last, b_tx_zlp, b_nak, b_busy, b_done, b_buf_err} !== 7'b0 || b_tx_dat !== 8'h00) begin
      failures++;
      $display("FAIL reset_d8: flags=%b dat=%h want 0", {b_tx_valid, b_tx_last, b_tx_zlp, b_nak, b_busy, b_done, b_buf_err}, b_tx_dat);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    sel = 1'b0;
    load_mem();
    run_transfer(18, 1'b0, 1'b0, -1, 1'b0, "t1_single");
  endtask

  task automatic test_zlp();
    sel = 1'b1;
    load_mem();
    run_transfer(16, 1'b1, 1'b0, -1, 1'b0, "t2_zlp");
    run_transfer(0, 1'b1, 1'b0, -1, 1'b0, "t2_len0");
  endtask

  task automatic test_retry();
    sel = 1'b1;
    load_mem();
    run_transfer(20, 1'b0, 1'b0, 1, 1'b0, "t3_retry");
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    load_mem();
    run_transfer(64, 1'b1, 1'b1, -1, 1'b0, "t4_bp64");
    run_transfer(70, 1'b0, 1'b1, -1, 1'b1, "t4_clamp");
  endtask

  task automatic test_nak_buf_err();
    sel = 1'b1;
    pkt_req = 1'b1;
    tick();
    pkt_req = 1'b0;
    checks++;
    if (nak !== 1'b1) begin
      failures++;
      $display("FAIL t5_nak: nak=%b want 1", nak);
    end
    tick();
    checks++;
    if (nak !== 1'b0) begin
      failures++;
      $display("FAIL t5_nak_width: nak=%b want 0", nak);
    end
    load_mem();
    do_arm(8, 1'b0, "t5_arm");
    buf_we = 1'b1;
    buf_adr = 6'd3;
    buf_dat = ~mem_m[1][3];
    tick();
    buf_we = 1'b0;
    checks++;
    if (buf_err !== 1'b1) begin
      failures++;
      $display("FAIL t5_buf_err: buf_err=%b want 1", buf_err);
    end
    tick();
    checks++;
    if (buf_err !== 1'b0) begin
      failures++;
      $display("FAIL t5_buf_err_width: buf_err=%b want 0", buf_err);
    end
    recv_packet(0, 8, 1'b0, "t5_ram_unchanged");
    pkt_ack = 1'b1;
    tick();
    pkt_ack = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL t5_done: done=%b want 1", done);
    end
    tick();
  endtask

  task automatic test_abort_reset();
    bit bad;
    sel = 1'b0;
    load_mem();
    do_arm(40, 1'b0, "t6_arm");
    tx_ready = 1'b1;
    pkt_req = 1'b1;
    tick();
    pkt_req = 1'b0;
    repeat (5) tick();
    checks++;
    if (tx_valid !== 1'b1) begin
      failures++;
      $display("FAIL t6_mid_send: tx_valid=%b want 1", tx_valid);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL t6_abort: valid=%b busy=%b done=%b want 0 0 0", tx_valid, busy, done);
    end
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (tx_valid !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL t6_abort_quiet: stray tx_valid or done after abort, want none");
    end
    run_transfer(5, 1'b0, 1'b0, -1, 1'b0, "t6_after_abort");

    do_arm(10, 1'b0, "t6_arm2");
    recv_packet(0, 10, 1'b0, "t6_pre_reset");
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL t6_reset: busy=%b valid=%b want 0 0", busy, tx_valid);
    end
    pkt_ack = 1'b1;
    tick();
    pkt_ack = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL t6_ack_after_reset: done=%b want 0", done);
    end
    pkt_req = 1'b1;
    tick();
    pkt_req = 1'b0;
    checks++;
    if (nak !== 1'b1) begin
      failures++;
      $display("FAIL t6_nak_after_reset: nak=%b want 1", nak);
    end
    load_mem();
    run_transfer(12, 1'b0, 1'b0, -1, 1'b0, "t6_after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      sel = 1'($urandom_range(0, 1));
      load_mem();
      run_transfer(int'($urandom_range(0, 70)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 4)) - 1,
                   1'($urandom_range(0, 1)), "rand");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; sel = 1'b0;
    buf_we = 1'b0; buf_adr = 6'd0; buf_dat = 8'h00;
    arm = 1'b0; arm_len = 7'd0; arm_zlp = 1'b0; abort = 1'b0;
    pkt_req = 1'b0; pkt_ack = 1'b0; pkt_retry = 1'b0; tx_ready = 1'b1;
    test_reset();
    test_single();
    test_zlp();
    test_retry();
    test_backpressure();
    test_nak_buf_err();
    test_abort_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
